key_filter: RTL and testbench

Debounces raw mechanical push-buttons and turns each confirmed press into a single-cycle pulse. It sits between the board key pins and the LED control logic, which expects one-clock `key_add` / `key_sub` / `key_shift_l` / `key_shift_r` strobes. Each key has its own synchronizer and debounce FSM. An optional auto-repeat mode re-fires the pulse while a key is held.

---
 rtl/key_filter_pkg.sv | 23 ++
 rtl/key_filter_ch.sv | 167 ++++++++++++++++
 rtl/key_filter.sv | 41 ++++
 tb/tb_key_filter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// -----------------------------------------------------------------------------
// key_filter_pkg : shared FSM state encoding and counter sizing for key_filter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package key_filter_pkg;

  localparam int c_STATE_W = 2;

  localparam logic [c_STATE_W-1:0] c_ST_IDLE       = 2'd0;
  localparam logic [c_STATE_W-1:0] c_ST_PRESS_FILT = 2'd1;
  localparam logic [c_STATE_W-1:0] c_ST_DOWN       = 2'd2;
  localparam logic [c_STATE_W-1:0] c_ST_REL_FILT   = 2'd3;

  // Bits needed to count 0 .. n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_filter_ch.sv
// -----------------------------------------------------------------------------
// key_filter_ch : one key channel - 2-flop synchronizer, debounce FSM, and
//                 auto-repeat timer when KEY_FILTER_REPEAT_EN is defined
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int CNT_MAX       = 1_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_press,
  output logic key_state,
  output logic key_release
);

  localparam int                 c_CNT_W    = cnt_width(CNT_MAX);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CNT_MAX - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 r_press;
  logic                 r_held;
  logic                 r_release;
  logic                 w_press_nxt;
  logic                 w_held_nxt;
  logic                 w_release_nxt;
  logic                 w_k;
  logic                 w_cnt_done;
  logic                 w_repeat_fire;

  // Synchronizer resets to "released" so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_k        = r_sync2;
  assign w_cnt_done = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_held    <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_held    <= w_held_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (!w_k) begin
          w_state_nxt = c_ST_PRESS_FILT;
          w_cnt_nxt   = '0;
        end
      end
      c_ST_PRESS_FILT: begin
        if (w_k) begin
          w_state_nxt = c_ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = c_ST_DOWN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      c_ST_DOWN: begin
        if (w_k) begin
          w_state_nxt = c_ST_REL_FILT;
          w_cnt_nxt   = '0;
        end
      end
      c_ST_REL_FILT: begin
        if (!w_k) begin
          w_state_nxt = c_ST_DOWN;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = c_ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the transition and registered with the state.
  always_comb begin
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_held_nxt    = (w_state_nxt == c_ST_DOWN) || (w_state_nxt == c_ST_REL_FILT);
    if ((r_state == c_ST_PRESS_FILT) && (w_state_nxt == c_ST_DOWN)) begin
      w_press_nxt = 1'b1;
    end
    if ((r_state == c_ST_DOWN) && (w_state_nxt == c_ST_DOWN) && w_repeat_fire) begin
      w_press_nxt = 1'b1;
    end
    if ((r_state == c_ST_REL_FILT) && (w_state_nxt == c_ST_IDLE)) begin
      w_release_nxt = 1'b1;
    end
  end

`ifdef KEY_FILTER_REPEAT_EN
  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_REP_W   = cnt_width(c_REP_MAX);
  localparam logic [c_REP_W-1:0] c_REP_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
  localparam logic [c_REP_W-1:0] c_REP_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

  logic [c_REP_W-1:0] r_rep_cnt;
  logic               r_rep_armed;

  // r_rep_armed marks that the initial delay has elapsed; later repeats use the period.
  assign w_repeat_fire = (r_state == c_ST_DOWN) &&
                         (r_rep_cnt == (r_rep_armed ? c_REP_PERIOD_LAST : c_REP_DELAY_LAST));

  always_ff @(posedge clk) begin
    if (reset || (r_state != c_ST_DOWN) || (w_state_nxt != c_ST_DOWN)) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_repeat_fire) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b1;
    end else begin
      r_rep_cnt <= r_rep_cnt + c_REP_W'(1);
    end
  end
`else
  assign w_repeat_fire = 1'b0;
`endif

  assign key_press   = r_press;
  assign key_state   = r_held;
  assign key_release = r_release;

endmodule

`default_nettype wire

// File: rtl/key_filter.sv
// -----------------------------------------------------------------------------
// key_filter : KEY_NUM independent debounced push-button channels with
//              press/release strobes; auto-repeat via KEY_FILTER_REPEAT_EN
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module key_filter
  import key_filter_pkg::*;
#(
  parameter int KEY_NUM       = 4,
  parameter int CNT_MAX       = 1_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_release
);

  for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_ch
    key_filter_ch #(
      .CNT_MAX       (CNT_MAX),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_in[gi]),
      .key_press   (key_press[gi]),
      .key_state   (key_state[gi]),
      .key_release (key_release[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_key_filter.sv
// -----------------------------------------------------------------------------
// tb_key_filter : directed self-checking bench for key_filter (CNT_MAX=8)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_key_filter;

  localparam int c_KEYS   = 4;
  localparam int c_CNT    = 8;
  localparam int c_RDELAY = 20;
  localparam int c_RPER   = 6;
  localparam int c_LAT    = c_CNT + 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [c_KEYS-1:0]   key_in;
  logic [c_KEYS-1:0]   key_press;
  logic [c_KEYS-1:0]   key_state;
  logic [c_KEYS-1:0]   key_release;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int press_cnt [c_KEYS];
  int rel_cnt   [c_KEYS];
  int last_press[c_KEYS];
  int last_rel  [c_KEYS];
  int overlap   = 0;

  key_filter #(
    .KEY_NUM       (c_KEYS),
    .CNT_MAX       (c_CNT),
    .REPEAT_DELAY  (c_RDELAY),
    .REPEAT_PERIOD (c_RPER)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_in      (key_in),
    .key_press   (key_press),
    .key_state   (key_state),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < c_KEYS; i++) begin
      press_cnt[i]  = 0;
      rel_cnt[i]    = 0;
      last_press[i] = -1;
      last_rel[i]   = -1;
    end
  end

  // Pulse log sampled mid-cycle; cyc is the index of the preceding posedge.
  always @(negedge clk) begin
    for (int i = 0; i < c_KEYS; i++) begin
      if (key_press[i] === 1'b1) begin
        press_cnt[i]++;
        last_press[i] = cyc;
      end
      if (key_release[i] === 1'b1) begin
        rel_cnt[i]++;
        last_rel[i] = cyc;
      end
      if ((key_press[i] === 1'b1) && (key_release[i] === 1'b1)) overlap++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] kin;
    int         n;
    logic [3:0] press;
    logic [3:0] held;
    logic [3:0] rel;
  } vec_t;

  vec_t vecs[16];

  int c_fall, c_rise, c_rel, c3, base_p, base_r, exp_cnt, exp_last;

  initial begin
    // Clean press on key 0, first low sample at N: press at N+10.
    vecs[0]  = '{4'b1110, 1,  4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b1110, 8,  4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b1110, 1,  4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b1110, 1,  4'b0001, 4'b0001, 4'b0000};
    vecs[4]  = '{4'b1110, 1,  4'b0000, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b1110, 5,  4'b0000, 4'b0001, 4'b0000};
    // Clean release on key 0, first high sample at M: release at M+10.
    vecs[6]  = '{4'b1111, 1,  4'b0000, 4'b0001, 4'b0000};
    vecs[7]  = '{4'b1111, 9,  4'b0000, 4'b0001, 4'b0000};
    vecs[8]  = '{4'b1111, 1,  4'b0000, 4'b0000, 4'b0001};
    vecs[9]  = '{4'b1111, 1,  4'b0000, 4'b0000, 4'b0000};
    // All four keys at once.
    vecs[10] = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b0000};
    vecs[11] = '{4'b0000, 1,  4'b1111, 4'b1111, 4'b0000};
    vecs[12] = '{4'b0000, 1,  4'b0000, 4'b1111, 4'b0000};
    vecs[13] = '{4'b1111, 10, 4'b0000, 4'b1111, 4'b0000};
    vecs[14] = '{4'b1111, 1,  4'b0000, 4'b0000, 4'b1111};
    vecs[15] = '{4'b1111, 1,  4'b0000, 4'b0000, 4'b0000};

    reset  = 1'b1;
    key_in = 4'b1111;
    step(3);
    check("reset press",   32'(key_press),   32'h0);
    check("reset state",   32'(key_state),   32'h0);
    check("reset release", 32'(key_release), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      key_in = vecs[i].kin;
      step(vecs[i].n);
      check($sformatf("row%0d press", i),   32'(key_press),   32'(vecs[i].press));
      check($sformatf("row%0d state", i),   32'(key_state),   32'(vecs[i].held));
      check($sformatf("row%0d release", i), 32'(key_release), 32'(vecs[i].rel));
    end

    // Bounce on key 1: 5 low, 2 high, then low and held.
    base_p = press_cnt[1];
    key_in[1] = 1'b0;
    step(5);
    key_in[1] = 1'b1;
    step(2);
    key_in[1] = 1'b0;
    c_fall = cyc + 1;
    step(15);
    check("bounce press count", 32'(press_cnt[1] - base_p), 32'd1);
    check("bounce press cycle", 32'(last_press[1]), 32'(c_fall + c_LAT));

    // Release of key 1 with a one-sample low blip.
    base_p = press_cnt[1];
    base_r = rel_cnt[1];
    key_in[1] = 1'b1;
    step(3);
    key_in[1] = 1'b0;
    step(1);
    key_in[1] = 1'b1;
    c_rise = cyc + 1;
    step(14);
    check("blip extra press", 32'(press_cnt[1] - base_p), 32'd0);
    check("blip release count", 32'(rel_cnt[1] - base_r), 32'd1);
    check("blip release cycle", 32'(last_rel[1]), 32'(c_rise + c_LAT));

    // Reset while key 2 is held down.
    key_in[2] = 1'b0;
    step(12);
    check("hold2 state", 32'(key_state[2]), 32'd1);
    reset = 1'b1;
    step(1);
    check("midreset press",   32'(key_press),   32'h0);
    check("midreset state",   32'(key_state),   32'h0);
    check("midreset release", 32'(key_release), 32'h0);
    step(1);
    check("midreset state 2", 32'(key_state), 32'h0);
    reset = 1'b0;
    c_rel  = cyc + 1;
    base_p = press_cnt[2];
    step(14);
    check("post-reset press count", 32'(press_cnt[2] - base_p), 32'd1);
    check("post-reset press cycle", 32'(last_press[2]), 32'(c_rel + c_LAT));
    check("post-reset state", 32'(key_state), 32'b0100);
    key_in = 4'b1111;
    step(14);
    check("key2 released", 32'(key_state), 32'h0);

    // Key 3 held for about 60 cycles: single press, or repeats when enabled.
    base_p = press_cnt[3];
    key_in[3] = 1'b0;
    c3 = cyc + 1;
    step(62);
`ifdef KEY_FILTER_REPEAT_EN
    exp_cnt  = 7;
    exp_last = c3 + c_LAT + c_RDELAY + 5 * c_RPER;
`else
    exp_cnt  = 1;
    exp_last = c3 + c_LAT;
`endif
    check("hold press count", 32'(press_cnt[3] - base_p), 32'(exp_cnt));
    check("hold last press",  32'(last_press[3]), 32'(exp_last));
    base_r = rel_cnt[3];
    key_in[3] = 1'b1;
    step(14);
    check("hold release count", 32'(rel_cnt[3] - base_r), 32'd1);

    check("press/release overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
